// File: rtl/load_align_unit.sv
// Load alignment/extension unit: fetches one or two aligned memory beats and returns a sign/zero-extended result.
// Optional macro MISALIGN_SPLIT_EN enables two-beat handling of loads straddling a beat boundary.
module load_align_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_mode,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

`ifdef MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, RESP} state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          mode_q;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [OFF_W-1:0]    req_off, off_q;
    logic [ADDR_W-1:0]   base_q;
    logic                accept;

    function automatic logic [3:0] access_size(input logic [2:0] mode);
        case (mode)
            3'd1, 3'd4: access_size = 4'd1;
            3'd2, 3'd5: access_size = 4'd2;
            3'd3, 3'd6: access_size = 4'd4;
            3'd7:       access_size = 4'd8;
            default:    access_size = 4'd0;
        endcase
    endfunction

    function automatic logic supported(input logic [2:0] mode);
        if (mode == 3'd6 || mode == 3'd7)
            supported = (DATA_W == 64);
        else
            supported = (mode != 3'd0);
    endfunction

    function automatic logic is_split(input logic [OFF_W-1:0] off, input logic [2:0] mode);
        is_split = (int'(off) + int'(access_size(mode))) > BYTES;
    endfunction

    // Shift the merged beat pair down to the addressed byte, then keep size*8 bits with the right extension.
    function automatic logic [DATA_W-1:0] extend(input logic [2*DATA_W-1:0] merged,
                                                 input logic [OFF_W-1:0]    off,
                                                 input logic [2:0]          mode);
        logic [2*DATA_W-1:0]      sh;
        logic [DATA_W-1:0]        lo;
        logic signed [DATA_W-1:0] s;
        int                       pad;
        sh  = merged >> {off, 3'b000};
        lo  = sh[DATA_W-1:0];
        pad = DATA_W - 8 * int'(access_size(mode));
        if (mode == 3'd1 || mode == 3'd2 || mode == 3'd3) begin
            s      = lo << pad;
            extend = s >>> pad;
        end else begin
            extend = (lo << pad) >> pad;
        end
    endfunction

    assign req_off = req_addr[OFF_W-1:0];
    assign off_q   = addr_q[OFF_W-1:0];
    assign base_q  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign accept  = req_valid && (state_q == IDLE);

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

`ifdef MISALIGN_SPLIT_EN
    logic [DATA_W-1:0] beat0_q;
    logic              beat0_we;

    always_ff @(posedge clk) begin
        if (beat0_we) beat0_q <= mem_rdata;
    end
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= req_addr;
            mode_q <= req_mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        rsp_valid     = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        beat0_we      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!supported(req_mode)) begin
                        state_d    = RESP;
                        rsp_data_d = '0;
                        rsp_err_d  = (req_mode != 3'd0);
`ifndef MISALIGN_SPLIT_EN
                    end else if (is_split(req_off, req_mode)) begin
                        state_d    = RESP;
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
`endif
                    end else begin
                        state_d = REQ0;
                    end
                end
            end
            REQ0: begin
                mem_req_valid = 1'b1;
                mem_addr      = base_q;
                if (mem_req_ready) state_d = WAIT0;
            end
            WAIT0: begin
                if (mem_rvalid) begin
`ifdef MISALIGN_SPLIT_EN
                    if (is_split(off_q, mode_q)) begin
                        beat0_we = 1'b1;
                        state_d  = REQ1;
                    end else
`endif
                    begin
                        state_d    = RESP;
                        rsp_data_d = extend({{DATA_W{1'b0}}, mem_rdata}, off_q, mode_q);
                        rsp_err_d  = 1'b0;
                    end
                end
            end
`ifdef MISALIGN_SPLIT_EN
            REQ1: begin
                mem_req_valid = 1'b1;
                mem_addr      = base_q + ADDR_W'(BYTES);
                if (mem_req_ready) state_d = WAIT1;
            end
            WAIT1: begin
                if (mem_rvalid) begin
                    state_d    = RESP;
                    rsp_data_d = extend({mem_rdata, beat0_q}, off_q, mode_q);
                    rsp_err_d  = 1'b0;
                end
            end
`endif
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit (DATA_W=32): byte-level memory model, scoreboard, random and directed loads.
module tb_load_align_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_mode = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;

    load_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_mode(req_mode),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          nb;
        int          lat;
        int          acc;
        bit          strict;
        bit          seen;
    } txn_t;

    txn_t        sb[$];
    logic [31:0] ea[$];
    logic [31:0] memw [64];
    int          errors = 0, checks = 0, cyc = 0, beats = 0;
    int          mem_stall = 0, rsp_stall = 0, fix_dly = 0;
    bit          rdy_rand = 0, rsp_rand = 0, spur_en = 0, strict = 1;
    bit          rd_pending = 0;
    int          rd_delay = 0;
    logic [31:0] rd_addr = '0;
    logic [31:0] last_d = '0;
    logic        last_e = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        w = memw[a[7:2]];
        return w[8*a[1:0] +: 8];
    endfunction

    // Reference: read the addressed bytes one by one, little-endian, then extend.
    function automatic txn_t model(input logic [31:0] a, input logic [2:0] m);
        txn_t        t;
        int          sz;
        bit          split;
        logic [63:0] v;
        t = '{d: 32'h0, e: 1'b0, nb: 0, lat: 1, acc: 0, strict: 1'b0, seen: 1'b0};
        case (m)
            3'd1, 3'd4: sz = 1;
            3'd2, 3'd5: sz = 2;
            3'd3, 3'd6: sz = 4;
            default:    sz = 8;
        endcase
        if (m == 3'd0) return t;
        if (m == 3'd6 || m == 3'd7) begin t.e = 1'b1; return t; end
        split = (int'(a[1:0]) + sz) > 4;
`ifndef MISALIGN_SPLIT_EN
        if (split) begin t.e = 1'b1; return t; end
`endif
        t.nb  = split ? 2 : 1;
        t.lat = split ? 5 : 3;
        v = '0;
        for (int i = 0; i < sz; i++) v = v | (64'(byte_at(a + 32'(i))) << (8 * i));
        if ((m == 3'd1 || m == 3'd2 || m == 3'd3) && v[8*sz-1]) v = v | ~((64'd1 << (8 * sz)) - 64'd1);
        t.d = v[31:0];
        return t;
    endfunction

    // Memory responder: accepts reads, returns data after 1+delay cycles, may inject stray rvalid.
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (rd_pending) begin
            if (rd_delay == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = memw[rd_addr[7:2]];
                rd_pending = 0;
            end else rd_delay--;
        end else if (spur_en && ($urandom % 6 == 0)) mem_rvalid = 1'b1;
        if (mem_stall > 0 && mem_req_valid) begin
            mem_req_ready = 1'b0;
            mem_stall--;
        end else mem_req_ready = rdy_rand ? ($urandom % 2 == 0) : 1'b1;
        if (mem_req_valid && !rst) begin
            if (ea.size() == 0) chk("unexpected_mem_req", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                chk("mem_addr", 64'(mem_addr), 64'(ea[0]));
                if (mem_req_ready) begin
                    void'(ea.pop_front());
                    beats++;
                    rd_pending = 1;
                    rd_addr    = mem_addr;
                    rd_delay   = (fix_dly >= 0) ? fix_dly : $urandom_range(0, 3);
                end
            end
        end
    end

    // Response checker: every cycle rsp_valid is high, outputs must equal the model's prediction.
    always @(negedge clk) begin
        if (rsp_stall > 0 && rsp_valid) begin
            rsp_ready = 1'b0;
            rsp_stall--;
        end else rsp_ready = rsp_rand ? ($urandom % 3 != 0) : 1'b1;
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            else begin
                if (!sb[0].seen) begin
                    sb[0].seen = 1;
                    if (sb[0].strict) chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                end
                chk("rsp_data", 64'(rsp_data), 64'(sb[0].d));
                chk("rsp_err", 64'(rsp_err), 64'(sb[0].e));
                if (rsp_ready) begin
                    chk("mem_beats", 64'(beats), 64'(sb[0].nb));
                    beats  = 0;
                    last_d = rsp_data;
                    last_e = rsp_err;
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic start_req(input logic [31:0] a, input logic [2:0] m);
        txn_t t;
        int   n;
        logic [31:0] base;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_mode = m;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk("req_ready_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        t = model(a, m);
        t.acc    = cyc;
        t.strict = strict;
        base = {a[31:2], 2'b00};
        if (t.nb >= 1) ea.push_back(base);
        if (t.nb == 2) ea.push_back(base + 32'd4);
        sb.push_back(t);
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_mode = 3'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin
            chk("rsp_timeout", 64'(sb.size()), 64'd0);
            sb.delete(); ea.delete(); beats = 0;
        end
    endtask

    task automatic do_req(input logic [31:0] a, input logic [2:0] m);
        start_req(a, m);
        wait_done();
    endtask

    initial begin
        txn_t t;
        int   n;
        for (int i = 0; i < 64; i++) memw[i] = $urandom;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        #2 rst = 1'b0;

        // LB sign extension of the top byte of a word.
        memw[0] = 32'h80FF1234;
        t = model(32'h103, 3'd1);
        chk("pin_lb", 64'(t.d), 64'hFFFFFF80);
        do_req(32'h103, 3'd1);
        chk("lb_data", 64'(last_d), 64'hFFFFFF80);
        chk("lb_err", 64'(last_e), 64'd0);

        memw[0] = 32'h12345678;
        t = model(32'h202, 3'd5);
        chk("pin_lhu", 64'(t.d), 64'h00001234);
        do_req(32'h202, 3'd5);
        chk("lhu_data", 64'(last_d), 64'h00001234);

        memw[0] = 32'hAB000000;
        memw[1] = 32'h000000CD;
        do_req(32'h303, 3'd2);
`ifdef MISALIGN_SPLIT_EN
        chk("split_lh_data", 64'(last_d), 64'hFFFFCDAB);
        chk("split_lh_err", 64'(last_e), 64'd0);
`else
        chk("split_lh_data", 64'(last_d), 64'd0);
        chk("split_lh_err", 64'(last_e), 64'd1);
`endif

        do_req(32'h100, 3'd7);
        chk("ld_on_32_err", 64'(last_e), 64'd1);
        chk("ld_on_32_data", 64'(last_d), 64'd0);
        do_req(32'h104, 3'd6);
        chk("lwu_on_32_err", 64'(last_e), 64'd1);
        do_req(32'h105, 3'd0);
        chk("noreg_err", 64'(last_e), 64'd0);

        // Address wrap-around across the top of the address space.
        memw[63] = 32'h4433_2211;
        memw[0]  = 32'h8877_6655;
        do_req(32'hFFFF_FFFE, 3'd3);
`ifdef MISALIGN_SPLIT_EN
        chk("wrap_lw_data", 64'(last_d), 64'h6655_4433);
`else
        chk("wrap_lw_err", 64'(last_e), 64'd1);
`endif

        // Backpressure on both memory and response sides.
        strict = 0;
        memw[2] = 32'hDEADBEEF;
        mem_stall = 3; rsp_stall = 2;
        do_req(32'h208, 3'd3);
        chk("bp_data", 64'(last_d), 64'hDEADBEEF);

        // Reset while waiting on the final beat; that beat arrives late and must be ignored.
        spur_en = 0; fix_dly = 6;
`ifdef MISALIGN_SPLIT_EN
        start_req(32'h303, 3'd2);
`else
        start_req(32'h300, 3'd3);
`endif
        n = 0;
        while (!(rd_pending && ea.size() == 0) && n < 50) begin @(negedge clk); n++; end
        chk("reached_last_wait", 64'(rd_pending && ea.size() == 0), 64'd1);
        #2 rst = 1'b1; sb.delete(); ea.delete(); beats = 0;
        #1;
        chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("mid_rst_rsp_err", 64'(rsp_err), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0; fix_dly = 0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_idle", 64'({req_ready, rsp_valid, mem_req_valid}), 64'b100);
        end
        strict = 1;
        memw[0] = 32'h80FF1234;
        do_req(32'h103, 3'd1);
        chk("post_rst_lb", 64'(last_d), 64'hFFFFFF80);

        // Randomised traffic.
        spur_en = 1;
        for (int i = 0; i < 64; i++) memw[i] = $urandom;
        for (int k = 0; k < 400; k++) begin
            rdy_rand = ($urandom % 2 == 0);
            rsp_rand = ($urandom % 2 == 0);
            fix_dly  = ($urandom % 2 == 0) ? 0 : -1;
            strict   = !rdy_rand && !rsp_rand && (fix_dly == 0);
            if ($urandom % 8 == 0) do_req(32'hFFFF_FFFC + 32'($urandom % 4), 3'($urandom_range(0, 7)));
            else do_req($urandom, 3'($urandom_range(0, 7)));
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/load_align_unit.md
# load_align_unit

Parametrised, multi-cycle load alignment and extension unit for the RISC-V pipeline's memory stage. It sits between the load/store path and the word-organised data memory and accepts one load request at a time. It fetches one or two aligned memory beats, merges and shifts the addressed bytes, and returns a sign- or zero-extended result. Unlike single-word combinational extraction, it handles loads that straddle a beat boundary by splitting them into two memory reads.

## Interface
- DATA_W, default 32: register and memory beat width; legal values 32 or 64. BYTES = DATA_W/8, OFF_W = log2(BYTES).
- ADDR_W, default 32: byte address width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  ADDR_W  byte address.
- req_mode  in  3  load mode (codes below).
- mem_req_valid  out  1  memory read request.
- mem_req_ready  in  1  memory accepts the read.
- mem_addr  out  ADDR_W  beat-aligned address; low OFF_W bits are always 0.
- mem_rvalid  in  1  read data valid; arrives at least 1 cycle after acceptance. At most one read is outstanding.
- mem_rdata  in  DATA_W  read beat.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  DATA_W  extended load result.
- rsp_err  out  1  request was unsupported; rsp_data is 0.

## Operation
- Mode codes: 0 NOREGWRITE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 LWU, 7 LD.
  - Codes 6 and 7 are legal only when DATA_W=64. With DATA_W=32 they are unsupported.
- Access size: 1 byte for LB/LBU, 2 for LH/LHU, 4 for LW/LWU, 8 for LD. off = req_addr[OFF_W-1:0].
- Split condition: off + size > BYTES. Under that condition the access needs beat0 at the aligned address and beat1 at the aligned address + BYTES. Address arithmetic wraps modulo 2^ADDR_W.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE: on req_valid, latch addr, mode and off.
    - If the mode is NOREGWRITE or unsupported, go to RESP with no memory access. rsp_data=0; rsp_err=1 only for an unsupported mode.
    - Otherwise go to REQ0.
  - REQ0: mem_req_valid=1 with the beat0 address. On mem_req_ready, go to WAIT0.
  - WAIT0: on mem_rvalid, capture beat0. Go to REQ1 if split, else to RESP.
  - REQ1: mem_req_valid=1 with the beat1 address. On mem_req_ready, go to WAIT1.
  - WAIT1: on mem_rvalid, capture beat1, then go to RESP.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE.
- Merge: form {beat1, beat0} (2·DATA_W bits; beat1=0 when not split) and shift right by off·8.
  - Take the low size·8 bits.
  - Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU.
  - LD and LW with DATA_W=32 pass through unchanged.
- rsp_data and rsp_err are registered and remain stable while rsp_valid is high.
- mem_rvalid outside WAIT0/WAIT1 is ignored.

## Timing
- Reset values: state IDLE; req_ready=1; mem_req_valid=0; mem_addr=0; rsp_valid=0; rsp_data=0; rsp_err=0.
- Assuming mem_req_ready=1, mem_rvalid one cycle after acceptance, and rsp_ready=1:
  - Non-split load: request accepted at cycle 0, rsp_valid at cycle 3.
  - Split load: rsp_valid at cycle 5.
  - NOREGWRITE or unsupported mode: rsp_valid at cycle 1.
- While mem_req_valid is high and mem_req_ready is low, mem_addr is held stable.
- The next request is accepted no earlier than the cycle after the rsp_valid/rsp_ready handshake, because req_ready is combinational on state==IDLE.
- Reset asserted mid-operation: immediate return to IDLE and reset values. Any in-flight memory response arriving afterwards is ignored.

## Configuration
- MISALIGN_SPLIT_EN defined: split loads perform two beats as described above.
- MISALIGN_SPLIT_EN undefined:
  - A load meeting the split condition issues no memory access and goes from IDLE to RESP with rsp_data=0 and rsp_err=1.
  - States REQ1 and WAIT1 are not built.

## Test plan
- DATA_W=32, LB, addr 0x103, mem_rdata 0x80FF1234 -> mem_addr 0x100; rsp_data 0xFFFFFF80, rsp_err=0; rsp_valid 3 cycles after acceptance.
- LHU, addr 0x202, mem_rdata 0x12345678 -> rsp_data 0x00001234 with a single memory beat.
- With MISALIGN_SPLIT_EN: LH, addr 0x303, beat0 0xAB000000 at 0x300, beat1 0x000000CD at 0x304 -> rsp_data 0xFFFFCDAB at cycle 5. Without the macro -> no memory request; rsp_data 0, rsp_err=1 at cycle 1.
- Backpressure: mem_req_ready low for 3 cycles in REQ0 and rsp_ready low for 2 cycles in RESP -> mem_addr and rsp_data held constant; exactly one memory request is issued.
- DATA_W=64, LWU, addr 0x1004, mem_rdata 0x89ABCDEF_00000000 -> rsp_data 0x0000000089ABCDEF. With DATA_W=32, mode 7 -> rsp_err=1, rsp_data 0.
- Reset pulse in WAIT1, followed by a late mem_rvalid -> state IDLE, all outputs at reset values, late data ignored, and the next request completes normally.
